// File: rtl/waterfall_pkg.sv
// Shared defaults and FSM state encoding for the waterfall pixel RAM scheduler.
package waterfall_pkg;

    localparam int unsigned WF_COLS = 320;
    localparam int unsigned WF_ROWS = 240;
    localparam int unsigned WF_AW   = 17;
    localparam int unsigned WF_DW   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_LINE_DONE,
        S_COMMIT
    } wf_state_e;

endpackage

// File: rtl/wf_addr_gen.sv
// Combinational (row, col, top) -> RAM address, with the row rotated by top and wrapped at ROWS.
module wf_addr_gen #(
    parameter int unsigned COLS = 320,
    parameter int unsigned ROWS = 240,
    parameter int unsigned AW   = 17
) (
    input  logic [7:0]    row,
    input  logic [8:0]    col,
    input  logic [7:0]    top,
    output logic [AW-1:0] addr
);

    logic [8:0] sum;
    logic [8:0] phys;

    always_comb begin
        sum  = {1'b0, row} + {1'b0, top};
        phys = (sum >= 9'(ROWS)) ? (sum - 9'(ROWS)) : sum;
        addr = AW'(phys) * AW'(COLS) + AW'(col);
    end

endmodule

// File: rtl/waterfall_scheduler.sv
// Shares the single-port waterfall RAM between strict-priority pixel fetch and the line writer,
// and scrolls the display by committing each finished line as the new top row at frame start.
module waterfall_scheduler
    import waterfall_pkg::*;
#(
    parameter int unsigned COLS = WF_COLS,
    parameter int unsigned ROWS = WF_ROWS,
    parameter int unsigned AW   = WF_AW,
    parameter int unsigned DW   = WF_DW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          vid_start,
    input  logic          vid_visible,
    input  logic [8:0]    vid_x,
    input  logic [7:0]    vid_y,
    input  logic          pix_rd_req,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic [DW-1:0] smp_data,
    input  logic          smp_sol,
    input  logic          smp_valid,
    output logic          smp_ready,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [7:0]    top_row,
    output logic          err_resync
);

    wf_state_e     state_q, state_d;
    logic [7:0]    wr_row_q, wr_row_d;
    logic [8:0]    wr_col_q, wr_col_d;
    logic [7:0]    top_row_q, top_row_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          rd_pend_q, rd_pend_d;
    logic          pix_valid_q, pix_valid_d;
    logic          err_q, err_d;
    logic          start_d_q, start_d_d;
    logic          start_rise_q, start_rise_d;

    logic          rd_cycle;
    logic          accept;
    logic          do_write;
    logic [8:0]    wr_col_sel;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    assign rd_cycle   = pix_rd_req && vid_visible;
    assign smp_ready  = resetn && !pix_rd_req && ((state_q == S_IDLE) || (state_q == S_WRITE));
    assign accept     = smp_valid && smp_ready;
    assign wr_col_sel = smp_sol ? '0 : wr_col_q;

    wf_addr_gen #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_rd_addr (
        .row  (vid_y),
        .col  (vid_x),
        .top  (top_row_q),
        .addr (rd_addr)
    );

    wf_addr_gen #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_wr_addr (
        .row  (wr_row_q),
        .col  (wr_col_sel),
        .top  ('0),
        .addr (wr_addr)
    );

    always_comb begin
        state_d      = state_q;
        wr_row_d     = wr_row_q;
        wr_col_d     = wr_col_q;
        top_row_d    = top_row_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        rd_pend_d    = rd_cycle;
        pix_valid_d  = rd_pend_q;
        err_d        = 1'b0;
        start_d_d    = vid_start;
        start_rise_d = vid_start && !start_d_q;
        do_write     = 1'b0;

        if (rd_cycle) begin
            ram_addr_d = rd_addr;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && smp_sol) begin
                    do_write = 1'b1;
                    wr_col_d = 9'd1;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    do_write = 1'b1;
                    if (smp_sol) begin
                        wr_col_d = 9'd1;
                        err_d    = 1'b1;
                    end else begin
                        wr_col_d = wr_col_q + 9'd1;
                        if (wr_col_q == 9'(COLS - 1)) begin
                            state_d = S_LINE_DONE;
                        end
                    end
                end
            end
            S_LINE_DONE: begin
                // ram_we_q is high only in the final-column write cycle; a rise seen then is skipped
                if (start_rise_q && !ram_we_q) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                top_row_d = wr_row_q;
                wr_row_d  = (wr_row_q == '0) ? 8'(ROWS - 1) : (wr_row_q - 8'd1);
                wr_col_d  = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_write) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = wr_addr;
            ram_wdata_d = smp_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            wr_row_q     <= 8'(ROWS - 1);
            wr_col_q     <= '0;
            top_row_q    <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            rd_pend_q    <= 1'b0;
            pix_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            start_d_q    <= 1'b0;
            start_rise_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_row_q     <= wr_row_d;
            wr_col_q     <= wr_col_d;
            top_row_q    <= top_row_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_pend_q    <= rd_pend_d;
            pix_valid_q  <= pix_valid_d;
            err_q        <= err_d;
            start_d_q    <= start_d_d;
            start_rise_q <= start_rise_d;
        end
    end

    // RAM returns data one clock after the address, so pix_data is passed through while valid
    assign pix_data   = pix_valid_q ? ram_rdata : '0;
    assign pix_valid  = pix_valid_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign top_row    = top_row_q;
    assign err_resync = err_q;

endmodule

// File: tb/tb_waterfall_scheduler.sv
// Directed bench for waterfall_scheduler: read latency/mapping, line writes, arbitration, resync, scroll.
module tb_waterfall_scheduler;

    localparam int COLS = 320;
    localparam int ROWS = 240;

    logic        clk;
    logic        resetn;
    logic        vid_start, vid_visible, pix_rd_req;
    logic [8:0]  vid_x;
    logic [7:0]  vid_y;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [7:0]  smp_data;
    logic        smp_sol, smp_valid, smp_ready;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  top_row;
    logic        err_resync;

    // Second instance with 4-column lines so a full 240-line scroll stays short
    logic        s_start, s_vis, s_req, s_sol, s_valid, s_ready, s_pix_valid, s_we, s_err;
    logic [8:0]  s_x;
    logic [7:0]  s_y, s_data, s_pix_data, s_wdata, s_top;
    logic [7:0]  s_rdata;
    logic [16:0] s_ram_addr;

    assign s_rdata = '0;

    waterfall_scheduler u_dut (
        .clk(clk), .resetn(resetn), .vid_start(vid_start), .vid_visible(vid_visible),
        .vid_x(vid_x), .vid_y(vid_y), .pix_rd_req(pix_rd_req), .pix_data(pix_data),
        .pix_valid(pix_valid), .smp_data(smp_data), .smp_sol(smp_sol), .smp_valid(smp_valid),
        .smp_ready(smp_ready), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .top_row(top_row), .err_resync(err_resync)
    );

    waterfall_scheduler #(.COLS(4), .ROWS(240), .AW(17), .DW(8)) u_small (
        .clk(clk), .resetn(resetn), .vid_start(s_start), .vid_visible(s_vis),
        .vid_x(s_x), .vid_y(s_y), .pix_rd_req(s_req), .pix_data(s_pix_data),
        .pix_valid(s_pix_valid), .smp_data(s_data), .smp_sol(s_sol), .smp_valid(s_valid),
        .smp_ready(s_ready), .ram_addr(s_ram_addr), .ram_we(s_we), .ram_wdata(s_wdata),
        .ram_rdata(s_rdata), .top_row(s_top), .err_resync(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: unwritten locations read back a fixed pattern (low address byte, addr 5 = 0x3C)
    logic [7:0] mem   [0:COLS*ROWS-1];
    logic       wflag [0:COLS*ROWS-1];

    function automatic logic [7:0] pre(input logic [16:0] a);
        return (a == 17'd5) ? 8'h3C : a[7:0];
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]   <= ram_wdata;
            wflag[ram_addr] <= 1'b1;
        end
        ram_rdata <= (wflag[ram_addr] === 1'b1) ? mem[ram_addr] : pre(ram_addr);
    end

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic        vis;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [16:0] addr;
        logic [7:0]  data;
    } rd_vec_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total, passed, we_cnt, wr_bad, err_cnt;
    int  base_we, base_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge; also scores RAM writes
    task automatic tick();
        @(posedge clk);
        #1;
        if (ram_we === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) wr_bad++;
            else begin
                mon_e = exp_q.pop_front();
                if (ram_addr !== mon_e.addr || ram_wdata !== mon_e.data) wr_bad++;
            end
        end
        if (err_resync === 1'b1) err_cnt++;
    endtask

    task automatic do_read(input logic vis, input logic [8:0] x, input logic [7:0] y,
                           input logic [16:0] eaddr, input logic [7:0] edata);
        pix_rd_req = 1'b1; vid_visible = vis; vid_x = x; vid_y = y;
        #1;
        check("rd_ready_blocked", 32'(smp_ready), 32'd0);
        tick();
        pix_rd_req = 1'b0; vid_visible = 1'b0;
        check("rd_addr", 32'(ram_addr), 32'(eaddr));
        check("rd_we_low", 32'(ram_we), 32'd0);
        tick();
        check("rd_valid", 32'(pix_valid), 32'(vis));
        check("rd_data", 32'(pix_data), vis ? 32'(edata) : 32'd0);
    endtask

    task automatic send_line(input int row, input int ncols, input int resync_at,
                             input bit every3, input bit start_at_end);
        int col;
        int cyc;
        int rdy_bad;
        bit resynced;
        col = 0; cyc = 0; rdy_bad = 0; resynced = 1'b0;
        while (col < ncols) begin
            smp_valid = 1'b1;
            if (every3 && (cyc % 3 == 2)) begin
                pix_rd_req = 1'b1; vid_visible = 1'b1;
                vid_x = 9'(cyc % COLS); vid_y = 8'd0;
                smp_sol = 1'b0; smp_data = 8'hEE;
                #1;
                if (smp_ready !== 1'b0) rdy_bad++;
                tick();
                pix_rd_req = 1'b0; vid_visible = 1'b0;
            end else begin
                bit rs;
                rs = (col == resync_at) && !resynced;
                if (rs) begin
                    resynced = 1'b1;
                    col = 0;
                end
                smp_sol  = (col == 0);
                smp_data = 8'(col);
                exp_q.push_back('{addr: 17'(row * COLS + col), data: 8'(col)});
                if (start_at_end && col == ncols - 1) vid_start = 1'b1;
                #1;
                if (smp_ready !== 1'b1) rdy_bad++;
                tick();
                if (rs) check("err_resync_pulse", 32'(err_resync), 32'd1);
                col++;
            end
            cyc++;
        end
        smp_valid = 1'b0; smp_sol = 1'b0;
        check("line_ready_pattern", 32'(rdy_bad), 32'd0);
    endtask

    task automatic frame_start();
        vid_start = 1'b1;
        repeat (3) tick();
        vid_start = 1'b0;
        repeat (3) tick();
    endtask

    rd_vec_t rd_tab[6];

    initial begin
        total = 0; passed = 0; we_cnt = 0; wr_bad = 0; err_cnt = 0;
        // Reads after the first commit (top_row = 239)
        rd_tab[0] = '{1'b1, 9'd7,   8'd0,   17'd76487, 8'h07};
        rd_tab[1] = '{1'b1, 9'd10,  8'd1,   17'd10,    8'h0A};
        rd_tab[2] = '{1'b1, 9'd319, 8'd239, 17'd76479, 8'hBF};
        rd_tab[3] = '{1'b1, 9'd50,  8'd100, 17'd31730, 8'hF2};
        rd_tab[4] = '{1'b0, 9'd3,   8'd3,   17'd31730, 8'h00};
        rd_tab[5] = '{1'b1, 9'd0,   8'd0,   17'd76480, 8'h00};

        resetn = 1'b0;
        vid_start = 0; vid_visible = 0; pix_rd_req = 0; vid_x = '0; vid_y = '0;
        smp_data = '0; smp_sol = 0; smp_valid = 0;
        s_start = 0; s_vis = 0; s_req = 0; s_x = '0; s_y = '0; s_data = '0; s_sol = 0; s_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_smp_ready", 32'(smp_ready), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_top_row", 32'(top_row), 32'd0);
        check("rst_err", 32'(err_resync), 32'd0);
        resetn = 1'b1;
        tick();
        check("idle_ready", 32'(smp_ready), 32'd1);

        // Fixed 2-clock read latency, then an invisible request that must not touch the RAM
        do_read(1'b1, 9'd5, 8'd0, 17'd5, 8'h3C);
        do_read(1'b0, 9'd9, 8'd4, 17'd5, 8'h00);

        // Reset mid-line at col 150
        send_line(239, 150, -1, 1'b0, 1'b0);
        check("pre_rst_we", 32'(ram_we), 32'd1);
        check("partial_writes", 32'(we_cnt), 32'd150);
        #1 resetn = 1'b0;
        #1;
        check("async_rst_we", 32'(ram_we), 32'd0);
        check("async_rst_addr", 32'(ram_addr), 32'd0);
        check("async_rst_wdata", 32'(ram_wdata), 32'd0);
        check("async_rst_ready", 32'(smp_ready), 32'd0);
        #3 resetn = 1'b1;
        tick();
        base_we = we_cnt;
        for (int i = 0; i < 5; i++) begin
            smp_valid = 1'b1; smp_sol = 1'b0; smp_data = 8'(i + 200);
            tick();
        end
        smp_valid = 1'b0;
        tick();
        check("nosol_dropped", 32'(we_cnt - base_we), 32'd0);

        // Full line into row 239, held in LINE_DONE until frame start
        base_we = we_cnt;
        send_line(239, COLS, -1, 1'b0, 1'b0);
        tick();
        check("line1_writes", 32'(we_cnt - base_we), 32'd320);
        check("line1_wr_bad", 32'(wr_bad), 32'd0);
        check("line1_q_empty", 32'(exp_q.size()), 32'd0);
        check("line1_done_ready", 32'(smp_ready), 32'd0);
        check("line1_top_before", 32'(top_row), 32'd0);
        smp_valid = 1'b1; smp_data = 8'h55;
        repeat (3) tick();
        smp_valid = 1'b0;
        check("line_done_holds", 32'(we_cnt - base_we), 32'd320);
        frame_start();
        check("commit1_top", 32'(top_row), 32'd239);
        for (int i = 0; i < 6; i++) begin
            do_read(rd_tab[i].vis, rd_tab[i].x, rd_tab[i].y, rd_tab[i].addr, rd_tab[i].data);
        end

        // Reads stealing every 3rd clock during a line write
        base_we = we_cnt;
        send_line(238, COLS, -1, 1'b1, 1'b0);
        tick();
        check("line2_writes", 32'(we_cnt - base_we), 32'd320);
        check("line2_wr_bad", 32'(wr_bad), 32'd0);
        check("line2_q_empty", 32'(exp_q.size()), 32'd0);
        frame_start();
        check("commit2_top", 32'(top_row), 32'd238);

        // Resync at col 100, and a frame start coinciding with the final column write
        base_we = we_cnt; base_err = err_cnt;
        send_line(237, COLS, 100, 1'b0, 1'b1);
        repeat (2) tick();
        vid_start = 1'b0;
        repeat (4) tick();
        check("line3_writes", 32'(we_cnt - base_we), 32'd420);
        check("line3_wr_bad", 32'(wr_bad), 32'd0);
        check("line3_err_count", 32'(err_cnt - base_err), 32'd1);
        check("no_commit_on_final", 32'(top_row), 32'd238);
        check("line3_done_ready", 32'(smp_ready), 32'd0);
        frame_start();
        check("commit3_top", 32'(top_row), 32'd237);
        do_read(1'b1, 9'd100, 8'd0, 17'd75940, 8'h64);

        // Full 240-line scroll on the 4-column instance
        for (int l = 0; l < 241; l++) begin
            for (int c = 0; c < 4; c++) begin
                s_valid = 1'b1; s_sol = (c == 0); s_data = 8'(c);
                if (l == 0 && c == 0) begin
                    #1;
                    check("small_ready", 32'(s_ready), 32'd1);
                end
                tick();
            end
            s_valid = 1'b0; s_sol = 1'b0;
            tick();
            s_start = 1'b1;
            repeat (3) tick();
            s_start = 1'b0;
            repeat (3) tick();
            check("scroll_top", 32'(s_top), (l < 240) ? 32'(239 - l) : 32'd239);
            if (l == 238) begin
                s_req = 1'b1; s_vis = 1'b1; s_x = 9'd2; s_y = 8'd239;
                tick();
                check("wrap_y239_addr", 32'(s_ram_addr), 32'd2);
                s_y = 8'd238;
                tick();
                check("wrap_y238_addr", 32'(s_ram_addr), 32'd958);
                s_req = 1'b0; s_vis = 1'b0;
                tick();
            end
        end
        check("small_last_wdata", 32'(s_wdata), 32'd3);
        check("small_idle_outs", 32'({s_we, s_err, s_pix_valid, s_pix_data}), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
